// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART receive register block: address map,
// STATUS / IRQ_EN bit positions and the legal DATA_SIZE range.
package apb_uart_pkg;

   localparam logic [3:0] ADDR_STATUS    = 4'h0;
   localparam logic [3:0] ADDR_BP_LO     = 4'h2;
   localparam logic [3:0] ADDR_BP_HI     = 4'h3;
   localparam logic [3:0] ADDR_DATA_SIZE = 4'h4;
   localparam logic [3:0] ADDR_COUNT     = 4'h5;
   localparam logic [3:0] ADDR_RX_DATA   = 4'h6;
   localparam logic [3:0] ADDR_IRQ_EN    = 4'h7;
   localparam logic [3:0] ADDR_THRESH    = 4'h8;

   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_FIFO_OVF  = 2;
   localparam int ST_FRAMING   = 3;
   localparam int ST_OVERRUN   = 4;
   localparam int ST_THRESH    = 5;

   localparam int IE_NOT_EMPTY = 0;
   localparam int IE_ERROR     = 1;
   localparam int IE_THRESH    = 2;

   localparam logic [7:0] DS_MIN = 8'd5;
   localparam logic [7:0] DS_MAX = 8'd8;

   function automatic logic size_legal(input logic [7:0] v);
      return (v >= DS_MIN) && (v <= DS_MAX);
   endfunction

endpackage

// File: rtl/apb_uart_rx_regs_rx_fifo.sv
// Synchronous receive FIFO with a combinational head output. A push into a
// full FIFO is only accepted when a pop frees a slot in the same cycle.
module rx_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // storage is never reset; the pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/apb_uart_rx_regs.sv
// APB register block in front of the UART receiver: configuration registers,
// RX byte buffering, sticky W1C error flags and a maskable registered irq.
module apb_uart_rx_regs
   import apb_uart_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int BP_W  = 14
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      rx_data,
   input  logic            data_ready,
   input  logic            overrun_error,
   input  logic            framing_error,
   input  logic            psel,
   input  logic            penable,
   input  logic            pwrite,
   input  logic [3:0]      paddr,
   input  logic [7:0]      pwdata,
   output logic [7:0]      prdata,
   output logic            pslverr,
   output logic            data_read,
   output logic [3:0]      data_size,
   output logic [BP_W-1:0] bit_period,
   output logic            irq
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic          access;
   logic          wr_acc;
   logic          rd_acc;
   logic          push_req;
   logic          pop_req;
   logic          ovf_set;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] thresh;
   logic [2:0]    irq_en;
   logic [2:0]    irq_src;
   logic          fifo_ovf;
   logic          framing;
   logic          overrun;
   logic          thr_hit;
   logic [7:0]    w1c_mask;
   logic [7:0]    status;
   logic [15:0]   bp_ext;

   assign access   = psel & penable;
   assign wr_acc   = access & pwrite;
   assign rd_acc   = access & ~pwrite;
   assign push_req = data_ready & ~data_read;
   assign pop_req  = rd_acc & (paddr == ADDR_RX_DATA) & ~fifo_empty;
   assign ovf_set  = push_req & fifo_full & ~pop_req;
   assign thr_hit  = (fifo_count >= thresh);
   assign w1c_mask = (wr_acc && paddr == ADDR_STATUS) ? pwdata : 8'h00;
   assign bp_ext   = 16'(bit_period);

   rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop_req),
      .wdata (rx_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      status               = 8'h00;
      status[ST_NOT_EMPTY] = ~fifo_empty;
      status[ST_FULL]      = fifo_full;
      status[ST_FIFO_OVF]  = fifo_ovf;
      status[ST_FRAMING]   = framing;
      status[ST_OVERRUN]   = overrun;
      status[ST_THRESH]    = thr_hit;
      irq_src              = 3'b000;
      irq_src[IE_NOT_EMPTY] = ~fifo_empty;
      irq_src[IE_ERROR]     = fifo_ovf | framing | overrun;
      irq_src[IE_THRESH]    = thr_hit;
   end

   // read mux and slave-error decode, live only during the access phase
   always_comb begin
      prdata  = 8'h00;
      pslverr = 1'b0;
      if (access) begin
         case (paddr)
            ADDR_STATUS:    if (!pwrite) prdata = status;
            ADDR_BP_LO:     if (!pwrite) prdata = bp_ext[7:0];
            ADDR_BP_HI:     if (!pwrite) prdata = bp_ext[15:8];
            ADDR_DATA_SIZE: begin
               if (pwrite) pslverr = ~size_legal(pwdata);
               else        prdata  = {4'h0, data_size};
            end
            ADDR_COUNT: begin
               if (pwrite) pslverr = 1'b1;
               else        prdata  = 8'(fifo_count);
            end
            ADDR_RX_DATA: begin
               if (pwrite || fifo_empty) pslverr = 1'b1;
               else                      prdata  = fifo_rdata;
            end
            ADDR_IRQ_EN:    if (!pwrite) prdata = {5'h00, irq_en};
            ADDR_THRESH:    if (!pwrite) prdata = 8'(thresh);
            default:        pslverr = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_period <= '0;
         data_size  <= 4'd8;
         irq_en     <= 3'b000;
         thresh     <= CW'(1);
         data_read  <= 1'b0;
         fifo_ovf   <= 1'b0;
         framing    <= 1'b0;
         overrun    <= 1'b0;
         irq        <= 1'b0;
      end else begin
         data_read <= push_req;
         // a set in the same cycle as its W1C wins
         fifo_ovf  <= (fifo_ovf & ~w1c_mask[ST_FIFO_OVF]) | ovf_set;
         framing   <= (framing  & ~w1c_mask[ST_FRAMING])  | framing_error;
         overrun   <= (overrun  & ~w1c_mask[ST_OVERRUN])  | overrun_error;
         irq       <= |(irq_en & irq_src);
         if (wr_acc) begin
            case (paddr)
               ADDR_BP_LO:     bit_period[7:0]      <= pwdata;
               ADDR_BP_HI:     bit_period[BP_W-1:8] <= pwdata[BP_W-9:0];
               ADDR_DATA_SIZE: if (size_legal(pwdata)) data_size <= pwdata[3:0];
               ADDR_IRQ_EN:    irq_en <= pwdata[2:0];
               ADDR_THRESH:    thresh <= pwdata[CW-1:0];
               default:        ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_apb_uart_rx_regs.sv
// Directed bench for apb_uart_rx_regs; APB read/err results are queued as
// expectations and checked by an independent monitor in each access phase.
module tb_apb_uart_rx_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        data_ready = 1'b0;
   logic        overrun_error = 1'b0;
   logic        framing_error = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [3:0]  paddr = 4'h0;
   logic [7:0]  pwdata = 8'h00;
   logic [7:0]  prdata;
   logic        pslverr;
   logic        data_read;
   logic [3:0]  data_size;
   logic [13:0] bit_period;
   logic        irq;

   typedef struct packed {
      logic [3:0] a;
      logic [7:0] d;
      logic       e;
      logic       chk;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   apb_uart_rx_regs #(.DEPTH(8), .BP_W(14)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .data_ready    (data_ready),
      .overrun_error (overrun_error),
      .framing_error (framing_error),
      .psel          (psel),
      .penable       (penable),
      .pwrite        (pwrite),
      .paddr         (paddr),
      .pwdata        (pwdata),
      .prdata        (prdata),
      .pslverr       (pslverr),
      .data_read     (data_read),
      .data_size     (data_size),
      .bit_period    (bit_period),
      .irq           (irq)
   );

   // monitor: every access phase consumes one queued expectation
   always @(negedge clk) begin
      if (psel && penable) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL apb_unexpected addr=%h prdata=%h pslverr=%b required=no access", paddr, prdata, pslverr);
         end else begin
            cur = exp_q.pop_front();
            if ((cur.chk && prdata !== cur.d) || pslverr !== cur.e || paddr !== cur.a) begin
               fails++;
               $display("FAIL apb_%s addr=%h prdata=%h pslverr=%b required addr=%h prdata=%h pslverr=%b",
                        cur.chk ? "rd" : "wr", paddr, prdata, pslverr, cur.a, cur.d, cur.e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic apb(input logic wr, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_e,
                      input logic frm = 1'b0, input logic push_en = 1'b0,
                      input logic [7:0] push_b = 8'h00);
      exp_t x;
      x.a = a; x.d = exp_d; x.e = exp_e; x.chk = ~wr;
      exp_q.push_back(x);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      framing_error = frm;
      if (push_en) begin
         rx_data = push_b;
         data_ready = 1'b1;
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      framing_error = 1'b0;
      if (push_en) begin
         chk("data_read_pushpop", data_read, 1'b1);
         data_ready = 1'b0;
      end
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] exp_d, input logic exp_e);
      apb(1'b0, a, 8'h00, exp_d, exp_e);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic exp_e);
      apb(1'b1, a, d, 8'h00, exp_e);
   endtask

   // receiver model: hold data_ready until data_read acknowledges it
   task automatic push_byte(input logic [7:0] b);
      @(posedge clk); #1;
      chk("data_read_idle", data_read, 1'b0);
      rx_data = b;
      data_ready = 1'b1;
      @(posedge clk); #1;
      chk("data_read_pulse", data_read, 1'b1);
      data_ready = 1'b0;
   endtask

   initial begin
      exp_t x;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_read", data_read, 1'b0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_bit_period", bit_period, 14'h0000);
      chk("rst_data_size", data_size, 4'd8);
      chk("idle_prdata", prdata, 8'h00);
      chk("idle_pslverr", pslverr, 1'b0);
      rst = 1'b0;
      rd(4'h0, 8'h00, 1'b0);
      rd(4'h4, 8'h08, 1'b0);
      rd(4'h8, 8'h01, 1'b0);

      // configuration registers
      wr(4'h2, 8'h34, 1'b0);
      wr(4'h3, 8'hFF, 1'b0);
      chk("bit_period", bit_period, 14'h3F34);
      rd(4'h3, 8'h3F, 1'b0);
      rd(4'h2, 8'h34, 1'b0);
      wr(4'h4, 8'h09, 1'b1);
      chk("data_size_illegal", data_size, 4'd8);
      wr(4'h4, 8'h04, 1'b1);
      wr(4'h4, 8'h05, 1'b0);
      chk("data_size_5", data_size, 4'd5);
      rd(4'h4, 8'h05, 1'b0);
      rd(4'hF, 8'h00, 1'b1);
      wr(4'hC, 8'h55, 1'b1);
      wr(4'h5, 8'h01, 1'b1);
      wr(4'h6, 8'h01, 1'b1);

      // basic push / pop
      push_byte(8'hA5);
      push_byte(8'h5A);
      rd(4'h5, 8'h02, 1'b0);
      rd(4'h0, 8'h21, 1'b0);
      rd(4'h6, 8'hA5, 1'b0);
      rd(4'h6, 8'h5A, 1'b0);
      rd(4'h6, 8'h00, 1'b1);
      rd(4'h5, 8'h00, 1'b0);

      // fill, overflow, then pop+push while full
      for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
      push_byte(8'hEE);
      rd(4'h0, 8'h27, 1'b0);
      rd(4'h5, 8'h08, 1'b0);
      wr(4'h0, 8'h04, 1'b0);
      rd(4'h0, 8'h23, 1'b0);
      apb(1'b0, 4'h6, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, 8'h77);
      rd(4'h5, 8'h08, 1'b0);
      rd(4'h0, 8'h23, 1'b0);
      for (int i = 1; i < 8; i++) rd(4'h6, 8'h10 + 8'(i), 1'b0);
      rd(4'h6, 8'h77, 1'b0);
      rd(4'h5, 8'h00, 1'b0);

      // threshold interrupt
      wr(4'h7, 8'h04, 1'b0);
      wr(4'h8, 8'h03, 1'b0);
      rd(4'h7, 8'h04, 1'b0);
      rd(4'h8, 8'h03, 1'b0);
      push_byte(8'hC0);
      push_byte(8'hC1);
      push_byte(8'hC2);
      chk("irq_same_cycle", irq, 1'b0);
      @(posedge clk); #1;
      chk("irq_rise", irq, 1'b1);
      rd(4'h6, 8'hC0, 1'b0);
      chk("irq_hold", irq, 1'b1);
      @(posedge clk); #1;
      chk("irq_fall", irq, 1'b0);
      rd(4'h6, 8'hC1, 1'b0);
      rd(4'h6, 8'hC2, 1'b0);
      wr(4'h7, 8'h00, 1'b0);

      // sticky error: set wins over W1C, then clears
      apb(1'b1, 4'h0, 8'h08, 8'h00, 1'b0, 1'b1);
      rd(4'h0, 8'h08, 1'b0);
      wr(4'h0, 8'h08, 1'b0);
      rd(4'h0, 8'h00, 1'b0);

      // overrun sticky drives the error interrupt
      @(posedge clk); #1;
      overrun_error = 1'b1;
      @(posedge clk); #1;
      overrun_error = 1'b0;
      wr(4'h7, 8'h02, 1'b0);
      @(posedge clk); #1;
      chk("irq_err", irq, 1'b1);
      rd(4'h0, 8'h10, 1'b0);
      wr(4'h0, 8'h10, 1'b0);
      @(posedge clk); #1;
      chk("irq_err_clr", irq, 1'b0);
      wr(4'h7, 8'h00, 1'b0);

      // reset during an RX_DATA access phase
      push_byte(8'h99);
      x.a = 4'h6; x.d = 8'h99; x.e = 1'b0; x.chk = 1'b1;
      exp_q.push_back(x);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h6;
      @(posedge clk); #1;
      penable = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      chk("rst_mid_bit_period", bit_period, 14'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      rd(4'h5, 8'h00, 1'b0);
      rd(4'h0, 8'h00, 1'b0);
      rd(4'h8, 8'h01, 1'b0);
      rd(4'h4, 8'h08, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_uart_rx_regs.md
# apb_uart_rx_regs

APB slave that fronts the UART receiver: holds its configuration (bit period, data size), buffers received bytes in a parametrised RX FIFO, and tracks sticky error flags with write-1-to-clear semantics. It also drives a maskable interrupt line. It is the next-generation register block between the APB bus and the receiver core, adding buffering, a threshold interrupt and parametrised bit-period width.

## Interface
Parameters:
- DEPTH, 8: RX FIFO entries; power of two, 2..64
- BP_W, 14: bit_period width; 9..16

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from receiver core
- data_ready  in  1  level; receiver holds a valid byte
- overrun_error  in  1  receiver overrun indication
- framing_error  in  1  receiver framing indication
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  4  register address
- pwdata  in  8  write data
- prdata  out  8  read data
- pslverr  out  1  slave error
- data_read  out  1  one-cycle acknowledge to receiver
- data_size  out  4  configured frame bits
- bit_period  out  BP_W  configured bit period in clocks
- irq  out  1  interrupt

## Operation
- Access phase = psel & penable. APB has zero wait states; pready is implied high.
- Register map:
  - 0x0 STATUS: [0] not_empty, [1] full, [2] fifo_ovf, [3] framing, [4] overrun, [5] count ≥ THRESH. RO, except W1C on [4:2].
  - 0x2 BP_LO: RW, bit_period[7:0].
  - 0x3 BP_HI: RW, bit_period[BP_W-1:8]; reads are zero-extended; unused write bits are ignored.
  - 0x4 DATA_SIZE: RW [3:0]. Legal values are 5..8. An illegal write leaves the register unchanged and raises pslverr.
  - 0x5 COUNT: RO, FIFO occupancy.
  - 0x6 RX_DATA: RO. A read returns the FIFO head and pops it.
  - 0x7 IRQ_EN: RW [2:0]; [0] not_empty, [1] any sticky error, [2] threshold.
  - 0x8 THRESH: RW, [$clog2(DEPTH):0].
- Any other address reads 0 and raises pslverr. Writes to it have no effect.
- pslverr also rises on:
  - a write to an RO register (0x5, 0x6);
  - an RX_DATA read while the FIFO is empty, which returns 0 and does not pop.
- A write to 0x0 is legal; it only performs the W1C.
- Push rule: push when data_ready & ~data_read.
  - data_read is registered high for exactly the cycle after each push attempt, including a dropped one.
  - The receiver drops data_ready in response to data_read.
- Push while full and no pop in the same cycle: the byte is dropped and fifo_ovf is set.
- Push and pop in the same cycle:
  - both take effect; count is unchanged;
  - when full, this is not an overflow;
  - when empty, the pop errors as above and the push still succeeds.
- framing_error and overrun_error set their sticky bits in any cycle they are high.
- If a sticky set and its W1C occur in the same cycle, set wins.
- irq = |(IRQ_EN & {count≥THRESH, |STATUS[4:2], not_empty}), registered.
- THRESH = 0 makes the threshold condition always true.

## Timing
- prdata and pslverr are combinational in the access phase and 0 outside it.
- Writes, pops and W1C commit at the clk edge that ends the access phase.
- Read-after-write sees the new value in the next transaction.
- Push latency: the byte is visible in COUNT and RX_DATA one cycle after data_ready is sampled.
- irq lags its condition by one cycle.
- Reset values, applied on the rst edge (mid-transfer as well):
  - FIFO emptied; all sticky bits 0
  - bit_period 0; DATA_SIZE 8; IRQ_EN 0; THRESH 1
  - data_read 0; irq 0
  - prdata and pslverr follow the combinational rule above (0 outside an access phase)
- A write or pop in progress during the reset cycle is discarded.

## Structure
- Package apb_uart_pkg holds:
  - register address localparams;
  - STATUS and IRQ_EN bit-index constants;
  - legal DATA_SIZE bounds.
- Sub-module rx_fifo: synchronous FIFO (DEPTH, width 8).
  - Ports: push, pop, wdata, rdata (head, combinational), full, empty, count.
  - Read/write pointers wrap modulo DEPTH.
- The top level holds the register file, APB decode, sticky logic and irq.

## Test plan
- Reset, then read 0x0, 0x4, 0x8 → prdata 0x00, 0x08, 0x01; pslverr 0.
- Write 0x2=0x34, 0x3=0xFF with BP_W=14 → bit_period 0x3F34; read of 0x3 returns 0x3F. Write 0x4=0x09 → pslverr 1, data_size stays 8.
- Push 0xA5 then 0x5A → COUNT 2; one data_read pulse per byte. RX_DATA reads return 0xA5 then 0x5A; a third read returns 0 with pslverr 1.
- Fill DEPTH bytes, push one more → STATUS[2]=1 and the extra byte is dropped. Pop and push in the same cycle while full → COUNT stays DEPTH, fifo_ovf stays clear after a prior W1C.
- Set IRQ_EN=0x4, THRESH=3, push 3 bytes → irq rises one cycle after the third push; a pop drops irq one cycle later.
- Pulse framing_error in the same cycle as W1C 0x08 → STATUS[3] stays 1. A subsequent W1C clears it. Assert rst during a pending RX_DATA read → FIFO empty, no pop observed.
